// File: rtl/scoreboard_ctrl_if.sv
// Decode-side scoreboard bus.
// master: decoder fields, flush and completion bus in; hazard/issue status out.
// slave : the scoreboard itself.
// Port summary (signal names mirror the scoreboard block's port list):
//   dec_v_i, rs1_v_i/rs1_adr_i, rs2_v_i/rs2_adr_i, rd_v_i/rd_adr_i, long_lat_i,
//   flush_v_q_i, cmpl_v_i/cmpl_adr_i             -> into scoreboard
//   stall_o, issue_v_o, pending_q_o, outstanding_q_o, sb_err_q_o -> out of scoreboard
interface scoreboard_ctrl_if #(
  parameter int NB_REGS = 32,
  parameter int CNT_W   = 3
);
  localparam int ADR_W = $clog2(NB_REGS);

  logic               dec_v_i;
  logic               rs1_v_i;
  logic [ADR_W-1:0]   rs1_adr_i;
  logic               rs2_v_i;
  logic [ADR_W-1:0]   rs2_adr_i;
  logic               rd_v_i;
  logic [ADR_W-1:0]   rd_adr_i;
  logic               long_lat_i;
  logic               flush_v_q_i;
  logic               cmpl_v_i;
  logic [ADR_W-1:0]   cmpl_adr_i;
  logic               stall_o;
  logic               issue_v_o;
  logic [NB_REGS-1:0] pending_q_o;
  logic [CNT_W-1:0]   outstanding_q_o;
  logic               sb_err_q_o;

  modport master (
    output dec_v_i, rs1_v_i, rs1_adr_i, rs2_v_i, rs2_adr_i, rd_v_i, rd_adr_i,
           long_lat_i, flush_v_q_i, cmpl_v_i, cmpl_adr_i,
    input  stall_o, issue_v_o, pending_q_o, outstanding_q_o, sb_err_q_o
  );

  modport slave (
    input  dec_v_i, rs1_v_i, rs1_adr_i, rs2_v_i, rs2_adr_i, rd_v_i, rd_adr_i,
           long_lat_i, flush_v_q_i, cmpl_v_i, cmpl_adr_i,
    output stall_o, issue_v_o, pending_q_o, outstanding_q_o, sb_err_q_o
  );
endinterface

// File: rtl/scoreboard_ctrl.sv
// Decode-stage scoreboard: tracks registers with in-flight long-latency writes,
// stalls decode on RAW/WAW hazards or when the outstanding-op limit is hit,
// and flags protocol errors on unexpected completions.
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   sb       - scoreboard_ctrl_if.slave (decoder fields, flush, completion in;
//              stall/issue (combinational), pending bits, count, sticky error out)
module scoreboard_ctrl #(
  parameter int NB_REGS     = 32,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 3
) (
  input logic              clk,
  input logic              reset_n,
  scoreboard_ctrl_if.slave sb
);

  logic [NB_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic raw1, raw2, waw, full, live, stall, issue, set, inc, dec;

  // Hazards look only at registered state: a completion this cycle does not
  // release a stall until the following cycle.
  assign raw1  = sb.rs1_v_i & (sb.rs1_adr_i != '0) & pending_q[sb.rs1_adr_i];
  assign raw2  = sb.rs2_v_i & (sb.rs2_adr_i != '0) & pending_q[sb.rs2_adr_i];
  assign waw   = sb.rd_v_i  & (sb.rd_adr_i  != '0) & pending_q[sb.rd_adr_i];
  assign full  = sb.long_lat_i & (cnt_q == CNT_W'(MAX_PENDING));

  // A flushed instruction neither stalls nor issues.
  assign live  = sb.dec_v_i & ~sb.flush_v_q_i;
  assign stall = live & (raw1 | raw2 | waw | full);
  assign issue = live & ~stall;

  assign set   = issue & sb.long_lat_i & sb.rd_v_i & (sb.rd_adr_i != '0);
  // x0 / rd-less long ops still occupy a unit slot, so they count.
  assign inc   = issue & sb.long_lat_i;
  // Never wrap below zero on a spurious completion.
  assign dec   = sb.cmpl_v_i & (cnt_q != '0);

  always_comb begin
    pending_d = pending_q;
    if (sb.cmpl_v_i) pending_d[sb.cmpl_adr_i] = 1'b0;
    // Applied after the clear so a new writer wins over the old one's completion.
    if (set)         pending_d[sb.rd_adr_i]   = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc, dec})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Completion with nothing outstanding, or to a non-pending non-x0 register.
  assign err_d = err_q | (sb.cmpl_v_i & ((cnt_q == '0) |
                 ((sb.cmpl_adr_i != '0) & ~pending_q[sb.cmpl_adr_i])));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign sb.stall_o         = stall;
  assign sb.issue_v_o       = issue;
  assign sb.pending_q_o     = pending_q;
  assign sb.outstanding_q_o = cnt_q;
  assign sb.sb_err_q_o      = err_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
module tb_scoreboard_ctrl;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  scoreboard_ctrl_if #(.NB_REGS(32), .CNT_W(3)) ifc ();
  scoreboard_ctrl #(.NB_REGS(32), .MAX_PENDING(MAXP), .CNT_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .sb(ifc.slave));

  typedef struct {
    bit dec, r1v; bit [4:0] r1; bit r2v; bit [4:0] r2;
    bit rdv; bit [4:0] rd; bit ll, fl, cv; bit [4:0] ca;
  } vec_t;

  typedef struct {
    vec_t in; bit s, i; logic [31:0] p; int c; bit e;
  } tv_t;

  int tests = 0;
  int fails = 0;

  // Reference model: set of pending registers, outstanding count, sticky error.
  bit m_pend[32];
  int m_cnt;
  bit m_err;

  function automatic vec_t V(bit dec, bit r1v, int r1, bit r2v, int r2, bit rdv, int rd,
                             bit ll, bit fl, bit cv, int ca);
    vec_t v;
    v.dec = dec; v.r1v = r1v; v.r1 = 5'(r1); v.r2v = r2v; v.r2 = 5'(r2);
    v.rdv = rdv; v.rd = 5'(rd); v.ll = ll; v.fl = fl; v.cv = cv; v.ca = 5'(ca);
    return v;
  endfunction

  function automatic vec_t IDLE(bit cv, int ca);
    return V(0, 0, 0, 0, 0, 0, 0, 0, 0, cv, ca);
  endfunction

  task automatic drive(vec_t v);
    ifc.dec_v_i = v.dec; ifc.rs1_v_i = v.r1v; ifc.rs1_adr_i = v.r1;
    ifc.rs2_v_i = v.r2v; ifc.rs2_adr_i = v.r2; ifc.rd_v_i = v.rdv;
    ifc.rd_adr_i = v.rd; ifc.long_lat_i = v.ll; ifc.flush_v_q_i = v.fl;
    ifc.cmpl_v_i = v.cv; ifc.cmpl_adr_i = v.ca;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, bit s, bit i, logic [31:0] p, int c, bit e);
    chk({tag, ".stall"}, 32'(ifc.stall_o), 32'(s));
    chk({tag, ".issue"}, 32'(ifc.issue_v_o), 32'(i));
    chk({tag, ".pend"},  ifc.pending_q_o, p);
    chk({tag, ".cnt"},   32'(ifc.outstanding_q_o), 32'(c));
    chk({tag, ".err"},   32'(ifc.sb_err_q_o), 32'(e));
  endtask

  // Drive one cycle's inputs away from the clock edge; outputs settle by #1.
  task automatic apply(vec_t v);
    @(negedge clk);
    drive(v);
    #1;
  endtask

  function automatic bit m_is_stall(vec_t v);
    bit hz;
    hz = (v.r1v && v.r1 != 0 && m_pend[v.r1]) || (v.r2v && v.r2 != 0 && m_pend[v.r2]) ||
         (v.rdv && v.rd != 0 && m_pend[v.rd]) || (v.ll && m_cnt == MAXP);
    return v.dec && !v.fl && hz;
  endfunction

  function automatic bit m_is_issue(vec_t v);
    return v.dec && !v.fl && !m_is_stall(v);
  endfunction

  function automatic logic [31:0] m_pend_vec();
    logic [31:0] r = '0;
    for (int k = 0; k < 32; k++) r[k] = m_pend[k];
    return r;
  endfunction

  task automatic m_update(vec_t v);
    bit iss = m_is_issue(v);
    int nc = m_cnt;
    if (v.cv) begin
      if (m_cnt == 0 || (v.ca != 0 && !m_pend[v.ca])) m_err = 1;
      if (m_cnt > 0) nc--;
      m_pend[v.ca] = 0;
    end
    if (iss && v.ll) begin
      nc++;
      if (v.rdv && v.rd != 0) m_pend[v.rd] = 1;
    end
    m_cnt = nc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(IDLE(0, 0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    foreach (m_pend[k]) m_pend[k] = 0;
    m_cnt = 0; m_err = 0;
  endtask

  tv_t tbl[15];

  initial begin
    // dec r1v r1 r2v r2 rdv rd ll fl cv ca  | stall issue pend cnt err (pre-edge)
    tbl[0]  = '{V(1,0,0,0,0,1,5,1,0,0,0), 0, 1, 32'h0,   0, 0};
    tbl[1]  = '{V(1,1,5,0,0,1,6,0,0,0,0), 1, 0, 32'h20,  1, 0};
    tbl[2]  = '{V(1,1,5,0,0,1,6,0,0,1,5), 1, 0, 32'h20,  1, 0};
    tbl[3]  = '{V(1,1,5,0,0,1,6,0,0,0,0), 0, 1, 32'h0,   0, 0};
    tbl[4]  = '{V(1,0,0,0,0,1,0,1,0,0,0), 0, 1, 32'h0,   0, 0};
    tbl[5]  = '{V(1,1,0,1,0,0,0,0,0,1,0), 0, 1, 32'h0,   1, 0};
    tbl[6]  = '{V(1,0,0,0,0,1,7,1,0,0,0), 0, 1, 32'h0,   0, 0};
    tbl[7]  = '{V(1,0,0,0,0,1,8,1,0,0,0), 0, 1, 32'h80,  1, 0};
    tbl[8]  = '{V(1,1,3,0,0,1,7,1,0,0,0), 1, 0, 32'h180, 2, 0};
    tbl[9]  = '{V(1,1,3,0,0,1,7,1,1,0,0), 0, 0, 32'h180, 2, 0};
    tbl[10] = '{V(1,1,3,0,0,1,7,1,0,1,7), 1, 0, 32'h180, 2, 0};
    tbl[11] = '{V(1,1,3,0,0,1,7,1,0,1,7), 0, 1, 32'h100, 1, 0};
    tbl[12] = '{IDLE(1,8),                0, 0, 32'h180, 1, 1};
    tbl[13] = '{IDLE(1,7),                0, 0, 32'h80,  0, 1};
    tbl[14] = '{IDLE(0,0),                0, 0, 32'h0,   0, 1};

    drive(IDLE(0, 0));
    #1;
    // Reset state, with a valid instruction held in decode during reset.
    ifc.dec_v_i = 1; ifc.long_lat_i = 1; ifc.rd_v_i = 1; ifc.rd_adr_i = 3;
    #1;
    chk_all("rst", 0, 1, 32'h0, 0, 0);
    ifc.flush_v_q_i = 1;
    #1;
    chk("rst.flush_issue", 32'(ifc.issue_v_o), 32'h0);
    do_reset();

    for (int t = 0; t < 15; t++) begin
      apply(tbl[t].in);
      chk_all($sformatf("tbl%0d", t), tbl[t].s, tbl[t].i, tbl[t].p, tbl[t].c, tbl[t].e);
    end

    // Outstanding limit: four long ops fill the units, fifth stalls.
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      apply(V(1,0,0,0,0,1,r,1,0,0,0));
      chk($sformatf("full.iss%0d", r), 32'(ifc.issue_v_o), 32'h1);
    end
    apply(V(1,0,0,0,0,1,5,1,0,0,0));
    chk_all("full.5th", 1, 0, 32'h1e, 4, 0);
    apply(V(1,1,10,0,0,1,9,0,0,0,0));
    chk_all("full.short", 0, 1, 32'h1e, 4, 0);
    apply(V(1,0,0,0,0,1,5,1,0,1,1));
    chk_all("full.cmpl", 1, 0, 32'h1e, 4, 0);
    apply(V(1,0,0,0,0,1,5,1,0,0,0));
    chk_all("full.go", 0, 1, 32'h1c, 3, 0);
    for (int r = 2; r <= 5; r++) apply(IDLE(1, r));
    apply(IDLE(1, 0));
    chk_all("drain", 0, 0, 32'h0, 0, 0);
    apply(IDLE(0, 0));
    chk_all("err.underflow", 0, 0, 32'h0, 0, 1);

    // Async reset in the middle of a stall.
    do_reset();
    apply(V(1,0,0,0,0,1,6,1,0,0,0));
    apply(V(1,1,6,0,0,0,0,0,0,0,0));
    chk_all("mid.stall", 1, 0, 32'h40, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk_all("mid.rst", 0, 1, 32'h0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    foreach (m_pend[k]) m_pend[k] = 0;
    m_cnt = 0; m_err = 0;
    apply(IDLE(1, 6));
    chk("mid.late_cmpl_pre", 32'(ifc.sb_err_q_o), 32'h0);
    apply(IDLE(0, 0));
    chk("mid.late_cmpl_err", 32'(ifc.sb_err_q_o), 32'h1);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      vec_t v;
      int np;
      if (n % 1000 == 999) do_reset();
      v.dec = ($urandom_range(0, 9) < 8);
      v.r1v = $urandom_range(0, 1); v.r1 = 5'($urandom_range(0, 7));
      v.r2v = $urandom_range(0, 1); v.r2 = 5'($urandom_range(0, 7));
      v.rdv = ($urandom_range(0, 3) != 0); v.rd = 5'($urandom_range(0, 9));
      v.ll = ($urandom_range(0, 9) < 4);
      v.fl = ($urandom_range(0, 19) == 0);
      v.cv = 0; v.ca = 0;
      np = 0;
      foreach (m_pend[k]) if (m_pend[k]) np++;
      if ($urandom_range(0, 9) < 3) begin
        int st = $urandom_range(1, 31);
        for (int k = 0; k < 31 && !v.cv; k++) begin
          int r = 1 + ((st - 1 + k) % 31);
          if (m_pend[r]) begin v.cv = 1; v.ca = 5'(r); end
        end
        if (!v.cv && m_cnt > np) begin v.cv = 1; v.ca = 0; end
      end
      if (!v.cv && $urandom_range(0, 99) == 0) begin
        v.cv = 1; v.ca = 5'($urandom_range(0, 31));
      end
      apply(v);
      chk_all($sformatf("rnd%0d", n), m_is_stall(v), m_is_issue(v), m_pend_vec(), m_cnt, m_err);
      m_update(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
